// File: rtl/vga_timing_monitor_if.sv
// rtl/vga_timing_monitor_if.sv - video snoop and monitor result bundle
//
// Groups the video signals under test together with the monitor results.
//   master : video source / bench side; drives hs, vs, de, r, g, b, clr_err
//   slave  : vga_timing_monitor side; drives locked, h_meas, v_meas, err,
//            frame_cnt, frame_ck, frame_valid
interface vga_timing_monitor_if #(
  parameter int COLOR_W = 4,
  parameter int CNT_W   = 12
);
  logic               hs;
  logic               vs;
  logic               de;
  logic [COLOR_W-1:0] r;
  logic [COLOR_W-1:0] g;
  logic [COLOR_W-1:0] b;
  logic               clr_err;
  logic               locked;
  logic [CNT_W-1:0]   h_meas;
  logic [CNT_W-1:0]   v_meas;
  logic [5:0]         err;
  logic [15:0]        frame_cnt;
  logic [15:0]        frame_ck;
  logic               frame_valid;

  modport master (
    output hs, vs, de, r, g, b, clr_err,
    input  locked, h_meas, v_meas, err, frame_cnt, frame_ck, frame_valid
  );

  modport slave (
    input  hs, vs, de, r, g, b, clr_err,
    output locked, h_meas, v_meas, err, frame_cnt, frame_ck, frame_valid
  );
endinterface

// File: rtl/vga_timing_monitor.sv
// rtl/vga_timing_monitor.sv - VGA timing and frame monitor
//
// Snoops a VGA stream, measures line/frame geometry, checks it against the
// configured resolution, keeps sticky error flags and a per-frame checksum.
// Ports:
//   clk              pixel clock
//   rst              asynchronous active-high reset
//   mon.hs/vs/de     syncs and active-video flag under test
//   mon.r/g/b        colour channels under test
//   mon.clr_err      one-cycle pulse clearing err
//   mon.locked       geometry matches parameters
//   mon.h_meas       last measured line period (clocks)
//   mon.v_meas       last measured frame period (lines)
//   mon.err          sticky flags: [0] h period [1] hs width [2] v period
//                    [3] vs width [4] de run length [5] active line count
//   mon.frame_cnt    frames completed while locked (wraps)
//   mon.frame_ck     checksum of last completed frame
//   mon.frame_valid  one-cycle pulse when frame_ck/v_meas update
module vga_timing_monitor #(
  parameter int COLOR_W  = 4,
  parameter int H_TOTAL  = 1056,
  parameter int H_ACTIVE = 800,
  parameter int H_SYNC_W = 128,
  parameter int V_TOTAL  = 628,
  parameter int V_ACTIVE = 600,
  parameter int V_SYNC_W = 4,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1,
  parameter int CNT_W    = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  vga_timing_monitor_if.slave  mon
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic             HS_ACT     = (HS_POL != 0);
  localparam logic             VS_ACT     = (VS_POL != 0);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] H_TOTAL_C  = CNT_W'(H_TOTAL);
  localparam logic [CNT_W-1:0] H_ACTIVE_C = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_C   = CNT_W'(H_SYNC_W);
  localparam logic [CNT_W-1:0] V_TOTAL_C  = CNT_W'(V_TOTAL);
  localparam logic [CNT_W-1:0] V_ACTIVE_C = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYNC_C   = CNT_W'(V_SYNC_W);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == CNT_MAX) ? x : x + CNT_W'(1);
  endfunction

  // Input sample registers
  logic               hs_q, vs_q, de_q;
  logic [COLOR_W-1:0] r_q, g_q, b_q;

  // Edge history and measurement state
  logic               hs_a_prev, vs_a_prev, de_prev;
  logic               h_seen;
  logic [CNT_W-1:0]   h_cnt, hs_w, v_cnt, vs_w, de_run, de_lines;
  logic [15:0]        ck;
  logic               frame_fail;
  state_t             state;

  // Registered outputs
  logic               locked_r;
  logic [CNT_W-1:0]   h_meas_r, v_meas_r;
  logic [5:0]         err_r;
  logic [15:0]        frame_cnt_r, frame_ck_r;
  logic               frame_valid_r;

  // Combinational decode of the sampled stream
  logic               hs_a, vs_a;
  logic               hs_lead, hs_trail, vs_lead, vs_trail, de_fall;
  logic [CNT_W-1:0]   h_per, de_lines_nxt;
  logic [5:0]         fail, new_err;
  logic [15:0]        pix, ck_next;

  always_comb begin
    hs_a     = (hs_q == HS_ACT);
    vs_a     = (vs_q == VS_ACT);
    hs_lead  = hs_a & ~hs_a_prev;
    hs_trail = ~hs_a & hs_a_prev;
    vs_lead  = vs_a & ~vs_a_prev;
    vs_trail = ~vs_a & vs_a_prev;
    de_fall  = ~de_q & de_prev;

    // A saturated counter must never alias to a legal period.
    h_per = (h_cnt == CNT_MAX) ? CNT_MAX : h_cnt + CNT_W'(1);

    // A de run ending on the vs edge cycle still belongs to the old frame.
    de_lines_nxt = de_fall ? sat_inc(de_lines) : de_lines;

    fail    = '0;
    fail[0] = hs_lead & h_seen & ((h_cnt == CNT_MAX) | (h_per != H_TOTAL_C));
    fail[1] = hs_trail & (hs_w != H_SYNC_C);
    fail[2] = vs_lead & ((v_cnt == CNT_MAX) | (v_cnt != V_TOTAL_C));
    fail[3] = vs_trail & (vs_w != V_SYNC_C);
    fail[4] = de_fall & (de_run != H_ACTIVE_C);
    fail[5] = vs_lead & (de_lines_nxt != V_ACTIVE_C);

    new_err = (state != IDLE) ? fail : 6'd0;

    pix     = 16'({r_q, g_q, b_q});
    ck_next = {ck[14:0], ck[15]} ^ pix;
  end

  // Measurement datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q          <= ~HS_ACT;
      vs_q          <= ~VS_ACT;
      de_q          <= 1'b0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      hs_a_prev     <= 1'b0;
      vs_a_prev     <= 1'b0;
      de_prev       <= 1'b0;
      h_seen        <= 1'b0;
      h_cnt         <= '0;
      hs_w          <= '0;
      v_cnt         <= '0;
      vs_w          <= '0;
      de_run        <= '0;
      de_lines      <= '0;
      ck            <= '0;
      h_meas_r      <= '0;
      v_meas_r      <= '0;
      err_r         <= '0;
      frame_ck_r    <= '0;
      frame_valid_r <= 1'b0;
    end else begin
      hs_q      <= mon.hs;
      vs_q      <= mon.vs;
      de_q      <= mon.de;
      r_q       <= mon.r;
      g_q       <= mon.g;
      b_q       <= mon.b;
      hs_a_prev <= hs_a;
      vs_a_prev <= vs_a;
      de_prev   <= de_q;

      if (hs_lead) begin
        h_cnt    <= '0;
        h_meas_r <= h_per;
        h_seen   <= 1'b1;
      end else begin
        h_cnt <= sat_inc(h_cnt);
      end

      hs_w <= hs_a ? sat_inc(hs_w) : '0;

      // An hs edge coincident with the vs edge is the first line of the new frame.
      if (vs_lead) begin
        v_cnt <= hs_lead ? CNT_W'(1) : '0;
      end else if (hs_lead) begin
        v_cnt <= sat_inc(v_cnt);
      end

      if (!vs_a) begin
        vs_w <= '0;
      end else if (hs_lead) begin
        vs_w <= sat_inc(vs_w);
      end

      de_run   <= de_q ? sat_inc(de_run) : '0;
      de_lines <= vs_lead ? '0 : de_lines_nxt;

      frame_valid_r <= vs_lead;
      if (vs_lead) begin
        frame_ck_r <= ck;
        v_meas_r   <= v_cnt;
        ck         <= '0;
      end else if (de_q) begin
        ck <= ck_next;
      end

      // A failure in the clearing cycle survives the clear.
      err_r <= (mon.clr_err ? 6'd0 : err_r) | new_err;
    end
  end

  // Lock FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      locked_r    <= 1'b0;
      frame_cnt_r <= '0;
      frame_fail  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          locked_r <= 1'b0;
          if (vs_lead) begin
            state      <= ACQ;
            frame_fail <= 1'b0;
          end
        end
        ACQ: begin
          if (vs_lead) begin
            frame_fail <= 1'b0;
            if (!(frame_fail | (|fail))) begin
              state    <= LOCKED;
              locked_r <= 1'b1;
            end
          end else begin
            frame_fail <= frame_fail | (|fail);
          end
        end
        LOCKED: begin
          if (|fail) begin
            state    <= IDLE;
            locked_r <= 1'b0;
          end else if (vs_lead) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
          end
        end
        default: begin
          state    <= IDLE;
          locked_r <= 1'b0;
        end
      endcase
    end
  end

  assign mon.locked      = locked_r;
  assign mon.h_meas      = h_meas_r;
  assign mon.v_meas      = v_meas_r;
  assign mon.err         = err_r;
  assign mon.frame_cnt   = frame_cnt_r;
  assign mon.frame_ck    = frame_ck_r;
  assign mon.frame_valid = frame_valid_r;

endmodule
